fetch_stage_mips: RTL and testbench

//  Fetch stage of the 5-stage MIPS pipeline: owns the program counter, drives the asynchronous-read

---
 rtl/fetch_stage_mips.sv | 129 ++++++++++++
 tb/tb_fetch_stage_mips.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_mips.sv
// MIPS fetch stage: program counter, next-PC selection, IF/ID pipeline register
// and saturating fetch/stall/flush event counters.
module fetch_stage_mips #(
    parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
    parameter int          COUNTER_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     resetMachine,
    input  logic                     enableProgramCounter_HazardUnit,
    input  logic                     enableFetch_HazardUnit,
    input  logic                     flushFetch_HazardUnit,
    input  logic                     enableJumpProgramCounter_Decode,
    input  logic [31:0]              jumpAddress_Decode,
    input  logic                     enableBranchProgramCounter_Execute,
    input  logic [31:0]              branchAddress_Execute,
    output logic [31:0]              addressInstructionMemory,
    input  logic [31:0]              readDataInstructionMemory,
    output logic [31:0]              instruction_Fetch,
    output logic [31:0]              programCounterPlus4_Fetch,
    output logic                     validInstruction_Fetch,
    output logic                     addressMisaligned_Fetch,
    output logic [COUNTER_WIDTH-1:0] fetchedCount_Fetch,
    output logic [COUNTER_WIDTH-1:0] stallCycleCount_Fetch,
    output logic [COUNTER_WIDTH-1:0] flushCount_Fetch
);

    typedef enum logic [1:0] {
        IFID_FLUSH,
        IFID_LOAD,
        IFID_HOLD
    } ifid_action_e;

    logic [31:0]              pc_q, pc_d;
    logic [31:0]              instr_q, instr_d;
    logic [31:0]              pc4_q, pc4_d;
    logic                     valid_q, valid_d;
    logic                     misaligned_q, misaligned_d;
    logic [COUNTER_WIDTH-1:0] fetched_q, fetched_d;
    logic [COUNTER_WIDTH-1:0] stall_q, stall_d;
    logic [COUNTER_WIDTH-1:0] flush_q, flush_d;
    logic [31:0]              pc_plus4;
    ifid_action_e             ifid_action;

    assign pc_plus4 = pc_q + 32'd4;

    // Saturating increment: adds one unless the counter is already all-ones.
    function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pc_d         = pc_q;
        misaligned_d = misaligned_q;
        if (enableBranchProgramCounter_Execute) begin
            pc_d = {branchAddress_Execute[31:2], 2'b00};
            if (branchAddress_Execute[1:0] != 2'b00) misaligned_d = 1'b1;
        end else if (enableProgramCounter_HazardUnit && enableJumpProgramCounter_Decode) begin
            pc_d = {jumpAddress_Decode[31:2], 2'b00};
            if (jumpAddress_Decode[1:0] != 2'b00) misaligned_d = 1'b1;
        end else if (enableProgramCounter_HazardUnit) begin
            pc_d = pc_plus4;
        end
    end

    // Flush outranks fetch enable, so a bubble is inserted even while stalled.
    always_comb begin
        ifid_action = IFID_HOLD;
        if (flushFetch_HazardUnit)       ifid_action = IFID_FLUSH;
        else if (enableFetch_HazardUnit) ifid_action = IFID_LOAD;
    end

    always_comb begin
        instr_d   = instr_q;
        pc4_d     = pc4_q;
        valid_d   = valid_q;
        fetched_d = fetched_q;
        stall_d   = stall_q;
        flush_d   = flush_q;
        unique case (ifid_action)
            IFID_FLUSH: begin
                instr_d = 32'h0000_0000;
                pc4_d   = 32'h0000_0000;
                valid_d = 1'b0;
                flush_d = sat_inc(flush_q);
            end
            IFID_LOAD: begin
                instr_d   = readDataInstructionMemory;
                pc4_d     = pc_plus4;
                valid_d   = 1'b1;
                fetched_d = sat_inc(fetched_q);
            end
            default: stall_d = sat_inc(stall_q);
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous and beats all inputs.
    always_ff @(posedge clock) begin
        if (!resetMachine) begin
            pc_q         <= RESET_VECTOR;
            instr_q      <= '0;
            pc4_q        <= '0;
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
            fetched_q    <= '0;
            stall_q      <= '0;
            flush_q      <= '0;
        end else begin
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
            misaligned_q <= misaligned_d;
            fetched_q    <= fetched_d;
            stall_q      <= stall_d;
            flush_q      <= flush_d;
        end
    end

    assign addressInstructionMemory  = pc_q;
    assign instruction_Fetch         = instr_q;
    assign programCounterPlus4_Fetch = pc4_q;
    assign validInstruction_Fetch    = valid_q;
    assign addressMisaligned_Fetch   = misaligned_q;
    assign fetchedCount_Fetch        = fetched_q;
    assign stallCycleCount_Fetch     = stall_q;
    assign flushCount_Fetch          = flush_q;

endmodule

// File: tb/tb_fetch_stage_mips.sv
// Bench for fetch_stage_mips: directed scenarios with literal expectations, then
// randomized hazard/branch/jump traffic checked every cycle against a behavioural model.
module tb_fetch_stage_mips;

    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pc_en, fetch_en, flush, jump, branch;
    logic [31:0]   jump_addr, branch_addr;
    logic [31:0]   imem_addr, imem_data;
    logic [31:0]   instr, pc4;
    logic          valid, misaligned;
    logic [CW-1:0] fetched_cnt, stall_cnt, flush_cnt;

    int vectors = 0;
    int miscompares = 0;

    // Model state
    bit          model_known = 1'b0;
    logic [31:0] m_pc, m_instr, m_pc4;
    bit          m_valid, m_mis;
    int          m_fetched, m_stall, m_flush;

    always #5 clk = ~clk;

    // Instruction memory contents are a pure function of the address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a | 32'hA000_0000;
    endfunction

    assign imem_data = mem(imem_addr);

    fetch_stage_mips #(.RESET_VECTOR(32'h0000_0000), .COUNTER_WIDTH(CW)) dut (
        .clock                              (clk),
        .resetMachine                       (rst_n),
        .enableProgramCounter_HazardUnit    (pc_en),
        .enableFetch_HazardUnit             (fetch_en),
        .flushFetch_HazardUnit              (flush),
        .enableJumpProgramCounter_Decode    (jump),
        .jumpAddress_Decode                 (jump_addr),
        .enableBranchProgramCounter_Execute (branch),
        .branchAddress_Execute              (branch_addr),
        .addressInstructionMemory           (imem_addr),
        .readDataInstructionMemory          (imem_data),
        .instruction_Fetch                  (instr),
        .programCounterPlus4_Fetch          (pc4),
        .validInstruction_Fetch             (valid),
        .addressMisaligned_Fetch            (misaligned),
        .fetchedCount_Fetch                 (fetched_cnt),
        .stallCycleCount_Fetch              (stall_cnt),
        .flushCount_Fetch                   (flush_cnt)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    // Apply the fetch-stage rules to the model for one rising edge.
    task automatic model_edge();
        logic [31:0] next_pc;
        if (!rst_n) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
            m_valid = 0; m_mis = 0; m_fetched = 0; m_stall = 0; m_flush = 0;
            model_known = 1'b1;
            return;
        end
        if (!model_known) return;
        next_pc = m_pc;
        if (branch) begin
            next_pc = branch_addr & 32'hFFFF_FFFC;
            if (branch_addr % 4 != 0) m_mis = 1;
        end else if (pc_en && jump) begin
            next_pc = jump_addr & 32'hFFFF_FFFC;
            if (jump_addr % 4 != 0) m_mis = 1;
        end else if (pc_en) begin
            next_pc = m_pc + 32'd4;
        end
        if (flush) begin
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 0; m_flush = sat(m_flush);
        end else if (fetch_en) begin
            m_instr = mem(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1; m_fetched = sat(m_fetched);
        end else begin
            m_stall = sat(m_stall);
        end
        m_pc = next_pc;
    endtask

    task automatic compare_all();
        if (!model_known) return;
        check("pc",         imem_addr,          m_pc);
        check("instr",      instr,              m_instr);
        check("pc4",        pc4,                m_pc4);
        check("valid",      32'(valid),         32'(m_valid));
        check("misaligned", 32'(misaligned),    32'(m_mis));
        check("fetched",    32'(fetched_cnt),   32'(m_fetched));
        check("stall",      32'(stall_cnt),     32'(m_stall));
        check("flush",      32'(flush_cnt),     32'(m_flush));
    endtask

    // One clock: model follows the edge, outputs are compared on the falling edge.
    task automatic cycle(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            compare_all();
        end
    endtask

    task automatic drive(input logic r, input logic pe, input logic fe, input logic fl,
                         input logic j, input logic [31:0] ja, input logic b, input logic [31:0] ba);
        rst_n = r; pc_en = pe; fetch_en = fe; flush = fl;
        jump = j; jump_addr = ja; branch = b; branch_addr = ba;
    endtask

    task automatic run_normal();
        drive(1, 1, 1, 0, 0, 32'h0, 0, 32'h0);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        @(negedge clk);

        // T1: reset state and sequential fetch
        cycle(2);
        check("t1_rst_addr",  imem_addr,        32'h0);
        check("t1_rst_valid", 32'(valid),       32'h0);
        check("t1_rst_cnt",   32'(fetched_cnt), 32'h0);
        run_normal();
        cycle();
        check("t1_addr1",  imem_addr, 32'h4);
        check("t1_instr1", instr,     32'hA000_0000);
        check("t1_pc4_1",  pc4,       32'h4);
        cycle();
        check("t1_addr2",  imem_addr, 32'h8);
        check("t1_instr2", instr,     32'hA000_0004);
        cycle(2);

        // T2: stall at 0x10
        check("t2_addr", imem_addr, 32'h10);
        drive(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        cycle(2);
        check("t2_hold_addr",  imem_addr,        32'h10);
        check("t2_hold_instr", instr,            32'hA000_000C);
        check("t2_stall",      32'(stall_cnt),   32'd2);
        check("t2_fetched",    32'(fetched_cnt), 32'd4);
        run_normal();
        cycle();
        check("t2_rel_addr",  imem_addr, 32'h14);
        check("t2_rel_instr", instr,     32'hA000_0010);

        // T3: jump with flush from PC 0x0C
        drive(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        cycle();
        run_normal();
        cycle(3);
        check("t3_addr", imem_addr, 32'hC);
        drive(1, 1, 1, 1, 1, 32'h40, 0, 32'h0);
        cycle();
        check("t3_jaddr", imem_addr,      32'h40);
        check("t3_instr", instr,          32'h0);
        check("t3_valid", 32'(valid),     32'h0);
        check("t3_flush", 32'(flush_cnt), 32'd1);

        // T4: branch beats jump; flush beats stall
        drive(1, 1, 0, 1, 1, 32'h40, 1, 32'h80);
        cycle();
        check("t4_addr",  imem_addr,      32'h80);
        check("t4_valid", 32'(valid),     32'h0);
        check("t4_stall", 32'(stall_cnt), 32'd0);
        check("t4_flush", 32'(flush_cnt), 32'd2);

        // T5: misaligned jump, sticky flag, PC wrap
        drive(1, 1, 1, 0, 1, 32'h42, 0, 32'h0);
        cycle();
        check("t5_addr", imem_addr,       32'h40);
        check("t5_mis",  32'(misaligned), 32'h1);
        run_normal();
        cycle(3);
        check("t5_mis_sticky", 32'(misaligned), 32'h1);
        drive(1, 1, 1, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
        cycle();
        check("t5_top", imem_addr, 32'hFFFF_FFFC);
        run_normal();
        cycle();
        check("t5_wrap", imem_addr, 32'h0);
        check("t5_wrap_pc4", pc4,   32'h0);

        // Reset beats branch and flush
        drive(0, 1, 1, 1, 1, 32'h40, 1, 32'h80);
        cycle();
        check("rst_ovr_addr", imem_addr,      32'h0);
        check("rst_ovr_mis",  32'(misaligned), 32'h0);
        check("rst_ovr_fl",   32'(flush_cnt),  32'h0);

        // Counter saturation
        run_normal();
        cycle(300);
        check("sat_fetched", 32'(fetched_cnt), 32'hFF);

        // Randomized traffic
        drive(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        cycle();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ja, ba;
            ja = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
            ba = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
            drive(logic'($urandom_range(0, 99) != 0),
                  logic'($urandom_range(0, 3) != 0),
                  logic'($urandom_range(0, 3) != 0),
                  logic'($urandom_range(0, 7) == 0),
                  logic'($urandom_range(0, 5) == 0), ja,
                  logic'($urandom_range(0, 7) == 0), ba);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
